// File: rtl/eth_tx_framer_if.sv
// Bundle of the framer's packet-request, FIFO-read and PHY-side signals.
// The framer drives through the master modport; the surrounding system uses slave.
interface eth_tx_framer_if;
  logic       tx_start;
  logic [8:0] pkt_len;
  logic [7:0] read_data;
  logic       fifo_empty;
  logic       read_enable;
  logic       read_start;
  logic       read_error;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_abort;
  logic       busy;
  logic       tx_err;
  logic       tx_done;
  logic [2:0] dbg_state;

  // A tx byte transfers on any rising edge where tx_valid && tx_ready; while
  // tx_valid is high and tx_ready low, tx_data holds and tx_valid stays high.
  modport master (
    input  tx_start, pkt_len, read_data, fifo_empty, tx_ready, tx_abort,
    output read_enable, read_start, read_error, tx_data, tx_valid,
           busy, tx_err, tx_done, dbg_state
  );

  modport slave (
    output tx_start, pkt_len, read_data, fifo_empty, tx_ready, tx_abort,
    input  read_enable, read_start, read_error, tx_data, tx_valid,
           busy, tx_err, tx_done, dbg_state
  );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, payload from a rollback FIFO, zero pad,
// CRC-32 FCS and inter-frame gap, with underrun and sink-abort recovery.
module eth_tx_framer #(
  parameter int MIN_PAYLOAD    = 46,
  parameter int MAX_LEN        = 510,
  parameter int IFG_CYCLES     = 12,
  parameter int UNDERRUN_LIMIT = 16
) (
  input logic           clk,
  input logic           n_rst,
  eth_tx_framer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam int CNT_W = 10;
  localparam int SC_W  = $clog2(UNDERRUN_LIMIT + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [8:0]       pay_left, pay_left_nxt;
  logic [8:0]       fetch_left;
  logic [7:0]       q0, q1;
  logic [1:0]       q_cnt;
  logic             rd_pending, started;
  logic [31:0]      crc, fcs;
  logic [SC_W-1:0]  starve_cnt;
  logic             err_q, rderr_q;

  logic tx_valid, accept, pop, rd_en, abort_now, underrun_now, kill;
  logic len_ok, reject, crc_en, done;
  logic [7:0] tx_data;
  logic [2:0] occ;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign len_ok = (bus.pkt_len != 9'd0) && ({23'd0, bus.pkt_len} <= MAX_LEN);
  assign fcs    = ~crc;

  assign tx_valid = (state == S_PREAMBLE) || (state == S_SFD) || (state == S_PAD) ||
                    (state == S_FCS) || ((state == S_PAYLOAD) && (q_cnt != 2'd0));
  assign accept   = tx_valid && bus.tx_ready;
  assign pop      = accept && (state == S_PAYLOAD);

  assign abort_now    = bus.tx_abort && (state != S_IDLE) && (state != S_IFG);
  assign underrun_now = (state == S_PAYLOAD) && (q_cnt == 2'd0) &&
                        (starve_cnt == SC_W'(UNDERRUN_LIMIT - 1));
  assign kill         = abort_now || underrun_now;

  // Occupancy the queue will have once every issued read lands, net of this cycle's pop.
  assign occ   = {1'b0, q_cnt} + {2'b0, rd_pending} - {2'b0, pop};
  assign rd_en = ((state == S_PREAMBLE) || (state == S_SFD) || (state == S_PAYLOAD)) &&
                 (fetch_left != 9'd0) && !bus.fifo_empty && !kill && (occ < 3'd2);

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    pay_left_nxt = pay_left;
    tx_data      = 8'h00;
    reject       = 1'b0;
    crc_en       = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.tx_start) begin
          if (len_ok) begin
            state_nxt    = S_PREAMBLE;
            byte_cnt_nxt = '0;
            pay_left_nxt = bus.pkt_len;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        tx_data = 8'h55;
        if (accept) begin
          if (byte_cnt == CNT_W'(6)) begin
            state_nxt    = S_SFD;
            byte_cnt_nxt = '0;
          end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end
      end
      S_SFD: begin
        tx_data = 8'hD5;
        if (accept) begin
          state_nxt    = S_PAYLOAD;
          byte_cnt_nxt = '0;
        end
      end
      S_PAYLOAD: begin
        tx_data = q0;
        if (accept) begin
          crc_en       = 1'b1;
          byte_cnt_nxt = byte_cnt + CNT_W'(1);
          pay_left_nxt = pay_left - 9'd1;
          if (pay_left == 9'd1) begin
            if (byte_cnt < CNT_W'(MIN_PAYLOAD - 1)) begin
              state_nxt = S_PAD;
            end else begin
              state_nxt    = S_FCS;
              byte_cnt_nxt = '0;
            end
          end
        end
      end
      S_PAD: begin
        if (accept) begin
          crc_en = 1'b1;
          if (byte_cnt == CNT_W'(MIN_PAYLOAD - 1)) begin
            state_nxt    = S_FCS;
            byte_cnt_nxt = '0;
          end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end
      end
      S_FCS: begin
        case (byte_cnt[1:0])
          2'd0:    tx_data = fcs[7:0];
          2'd1:    tx_data = fcs[15:8];
          2'd2:    tx_data = fcs[23:16];
          default: tx_data = fcs[31:24];
        endcase
        if (accept) begin
          if (byte_cnt == CNT_W'(3)) begin
            state_nxt    = S_IFG;
            byte_cnt_nxt = '0;
            done         = !abort_now;
          end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end
      end
      S_IFG: begin
        if (byte_cnt == CNT_W'(IFG_CYCLES - 1)) begin
          state_nxt    = S_IDLE;
          byte_cnt_nxt = '0;
        end else begin
          byte_cnt_nxt = byte_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (kill) begin
      state_nxt    = S_IFG;
      byte_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      pay_left   <= '0;
      fetch_left <= '0;
      q0         <= '0;
      q1         <= '0;
      q_cnt      <= '0;
      rd_pending <= 1'b0;
      started    <= 1'b0;
      crc        <= 32'hFFFFFFFF;
      starve_cnt <= '0;
      err_q      <= 1'b0;
      rderr_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      pay_left   <= pay_left_nxt;
      err_q      <= reject || kill;
      rderr_q    <= kill;
      rd_pending <= rd_en;
      if ((state == S_IDLE) && bus.tx_start && len_ok) begin
        fetch_left <= bus.pkt_len;
        started    <= 1'b0;
        crc        <= 32'hFFFFFFFF;
      end else begin
        if (rd_en) begin
          fetch_left <= fetch_left - 9'd1;
          started    <= 1'b1;
        end
        if (crc_en) crc <= crc_byte(crc, tx_data);
      end
      if ((state == S_PAYLOAD) && (q_cnt == 2'd0)) starve_cnt <= starve_cnt + SC_W'(1);
      else starve_cnt <= '0;
      // A kill drops both queued bytes and the byte landing from last cycle's read.
      if (kill) begin
        q_cnt <= 2'd0;
      end else begin
        case ({rd_pending, pop})
          2'b11: begin
            if (q_cnt == 2'd2) begin
              q0 <= q1;
              q1 <= bus.read_data;
            end else begin
              q0 <= bus.read_data;
            end
          end
          2'b01: begin
            q0    <= q1;
            q_cnt <= q_cnt - 2'd1;
          end
          2'b10: begin
            if (q_cnt == 2'd0) q0 <= bus.read_data;
            else q1 <= bus.read_data;
            q_cnt <= q_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.read_enable = rd_en;
  assign bus.read_start  = rd_en && !started;
  assign bus.read_error  = rderr_q;
  assign bus.tx_data     = tx_data;
  assign bus.tx_valid    = tx_valid;
  assign bus.busy        = (state != S_IDLE);
  assign bus.tx_err      = err_q;
  assign bus.tx_done     = done;
  assign bus.dbg_state   = state;

endmodule
